suma_serie: RTL and testbench
=============================

Name: suma_serie

Overview:
- Multi-cycle N-bit adder/subtractor for the calculator datapath. Processes DIGIT bits per clock through a registered carry, LSB slice first.
- Operands are launched with a start/busy/done handshake.
- Reports sum, carry-out and signed overflow.
- Replaces the per-bit combinational adder chain where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT
- DIGIT, 1, bits added per clock cycle (slice width); 1 ≤ DIGIT ≤ WIDTH

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch request; sampled only when busy=0
- op  input  1  0 = add (a+b+cin), 1 = subtract (a−b−cin)
- a  input  WIDTH  operand A, captured at accepted start
- b  input  WIDTH  operand B, captured at accepted start
- cin  input  1  carry-in (add) / borrow-in (sub), captured at accepted start
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse when result registers update
- s  output  WIDTH  result, registered
- cout  output  1  raw final carry; in sub mode 1 = no borrow
- ovf  output  1  two's-complement overflow of the result

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, s=0, cout=0, ovf=0; internal operand, carry and slice counter cleared.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at a rising edge → capture a, b' (b' = op ? ~b : b), carry0 = cin ^ op; counter=0; go to RUN.
  - RUN: each cycle, add slice [counter*DIGIT +: DIGIT] of a and b' with the registered carry, store the slice sum, update the carry, increment the counter.
  - RUN → DONE: after slice N−1 (N = WIDTH/DIGIT) completes.
  - DONE: lasts exactly one cycle, then IDLE. Exception: start=1 in DONE is accepted exactly as in IDLE and goes straight to RUN.
- Latency: start accepted at edge k → busy=1 for cycles k+1 … k+N; done=1 and new s/cout/ovf visible at cycle k+N+1; busy=0 in that cycle.
- Outputs s, cout, ovf change only when entering DONE and hold until the next DONE. Partial sums are never visible on s.
- ovf = carry into MSB XOR carry out of MSB (equivalently a[MSB] ^ b'[MSB] ^ s[MSB] ^ cout).
- Arithmetic is modulo 2^WIDTH. Sub computes a + ~b + ~cin.
- start while busy=1 is ignored: no queuing, operands not re-captured. Inputs a, b, op, cin may change freely after acceptance.
- done is never asserted without a preceding accepted start.
- rst asserted mid-RUN aborts immediately:
  - all outputs return to reset values;
  - no done pulse for the aborted operation;
  - after rst release, the next start behaves normally.
- DIGIT = WIDTH is legal: N=1, busy for one cycle.

Optional Feature:
- Macro: SUMA_ACC_EN.
- Defined:
  - Adds input port acc (1 bit).
  - If acc=1 at an accepted start, operand A is taken from the current s register instead of port a, giving a running accumulator (s ← s ± b ± cin).
  - op, cin and the handshake are unchanged.
  - acc is ignored while busy.
- Not defined: port acc does not exist; operand A always comes from port a.

Test Plan:
- Reset: pulse rst asynchronously (between edges), WIDTH=8, DIGIT=1 → busy=0, done=0, s=0x00, cout=0, ovf=0 immediately, before the next clk edge.
- Add, WIDTH=8, DIGIT=1, a=0x7F, b=0x01, cin=0, op=0, start one cycle → busy high 8 cycles; done pulses 1 cycle at cycle 9; s=0x80, cout=0, ovf=1.
- Sub, a=0x05, b=0x07, cin=0, op=1 → s=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01, cin=0, op=1 → s=0x7F, cout=1, ovf=1.
- Carry-in and back-to-back: add 0xFF+0x00 with cin=1 → s=0x00, cout=1, ovf=0. Assert start during the DONE cycle with a=0x10, b=0x20 → accepted, next done gives s=0x30; start pulses during busy have no effect.
- Abort and slice width: rst mid-RUN at slice 4 → outputs zero, no done pulse; then DIGIT=4, 0x3C+0x0F → busy 2 cycles, s=0x4B, cout=0, ovf=0.
- SUMA_ACC_EN defined: start a=0x10, b=0x05, acc=0 → s=0x15; then acc=1, b=0x05 → s=0x1A; then acc=1, op=1, b=0x1A → s=0x00, cout=1.

Source files
------------

// File: rtl/suma_serie.sv
// suma_serie: multi-cycle adder/subtractor that processes DIGIT bits per clock.
// The operands are captured in shift registers and consumed LSB slice first.
// A single registered carry links one slice to the next.
// Handshake: start is taken when busy=0, in IDLE or DONE. busy is high while
// slices are processed. done is a one-cycle pulse that marks the update of
// s/cout/ovf.
// Optional feature macro: SUMA_ACC_EN adds the input acc. When acc=1 at an
// accepted start, operand A is taken from the current s register.
module suma_serie #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUMA_ACC_EN
    input  logic             acc,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] opa, opb, psum, psum_next, a_sel;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic [DIGIT:0]   slice_sum;

    // Operand A source: the port, or the running result when accumulating.
`ifdef SUMA_ACC_EN
    assign a_sel = acc ? s : a;
`else
    assign a_sel = a;
`endif

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(N - 1));

    // Current slice: the low DIGIT bits of the shifted operands plus the carry.
    assign slice_sum = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};

    // The partial sum fills from the top, so after N slices it is aligned.
    assign psum_next = (psum >> DIGIT)
                     | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic. DONE accepts a new start just like IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture at accept, shift one slice per RUN cycle, publish on last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa   <= a_sel;
            opb   <= op ? ~b : b;
            carry <= cin ^ op;
            cnt   <= '0;
            psum  <= '0;
        end else if (state == RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            carry <= slice_sum[DIGIT];
            psum  <= psum_next;
            cnt   <= cnt + CW'(1);
            if (last) begin
                s    <= psum_next;
                cout <= slice_sum[DIGIT];
                // On the last slice, bit DIGIT-1 of the operands holds the original MSBs.
                ovf  <= opa[DIGIT-1] ^ opb[DIGIT-1] ^ slice_sum[DIGIT-1] ^ slice_sum[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_suma_serie.sv
// tb_suma_serie: directed test of suma_serie.
// u_dut uses WIDTH=8, DIGIT=1. u_dut4 uses WIDTH=8, DIGIT=4.
// Define SUMA_ACC_EN to also exercise the accumulator input.
module tb_suma_serie;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, op = 1'b0, cin = 1'b0, acc = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout, ovf;
    logic [7:0] s;

    logic       start4 = 1'b0, op4 = 1'b0, cin4 = 1'b0, acc4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] s4;

    int checks = 0;
    int failures = 0;

    // clock / reset block
    always #5 clk = ~clk;

    suma_serie #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
`ifdef SUMA_ACC_EN
        .acc(acc),
`endif
        .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
    );

    suma_serie #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4), .cin(cin4),
`ifdef SUMA_ACC_EN
        .acc(acc4),
`endif
        .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver: present one start, return #1 after the accepting edge
    task automatic launch(input logic [7:0] a_v, input logic [7:0] b_v,
                          input logic cin_v, input logic op_v, input logic acc_v);
        a = a_v; b = b_v; cin = cin_v; op = op_v; acc = acc_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // wait for done (bounded), counting busy cycles and watching that s holds
    task automatic wait_done(output int cycles, output bit hold_ok);
        logic [7:0] hold;
        int guard;
        hold = s; cycles = 0; hold_ok = 1'b1; guard = 0;
        while (!done && guard < 40) begin
            if (busy) cycles++;
            if (s !== hold) hold_ok = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
    endtask

    // full operation on u_dut with expected result; returns in the DONE cycle
    task automatic run_op(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                          input logic cin_v, input logic op_v, input logic acc_v,
                          input logic [7:0] exp_s, input logic exp_c, input logic exp_o);
        int cyc;
        bit hold_ok;
        launch(a_v, b_v, cin_v, op_v, acc_v);
        wait_done(cyc, hold_ok);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_busy_cycles"}, cyc, 32'd8);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_s_hold"}, {31'b0, hold_ok}, 32'd1);
        check({tag, "_s"}, {24'b0, s}, {24'b0, exp_s});
        check({tag, "_cout"}, {31'b0, cout}, {31'b0, exp_c});
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_o});
    endtask

    initial begin
        int cyc;
        bit hold_ok;
        bit seen_done;
        int guard;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_s", {24'b0, s}, 32'h00);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // add with signed overflow, then done pulse width
        run_op("add7f", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("add7f_done_one_cycle", {31'b0, done}, 32'd0);

        // asynchronous reset pulse between edges clears outputs immediately
        #2 rst = 1'b1;
        #1;
        check("arst_s", {24'b0, s}, 32'h00);
        check("arst_ovf", {31'b0, ovf}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // subtraction
        run_op("sub5m7", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        run_op("sub80m1", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

        // carry-in, then start in the DONE cycle
        run_op("addff_cin", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        launch(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
        check("b2b_accepted", {31'b0, busy}, 32'd1);
        // start pulses during busy must be ignored
        a = 8'hAA; b = 8'h55; start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, hold_ok);
        check("b2b_done", {31'b0, done}, 32'd1);
        check("b2b_s", {24'b0, s}, 32'h30);
        check("b2b_s_hold", {31'b0, hold_ok}, 32'd1);
        @(posedge clk); #1;
        check("busy_start_ignored", {30'b0, busy, done}, 32'd0);

        // abort mid-run at slice 4
        launch(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_s", {24'b0, s}, 32'h00);
        check("abort_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'b0, seen_done}, 32'd0);
        run_op("after_abort", 8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);

        // DIGIT=4 instance: two slices
        a4 = 8'h3C; b4 = 8'h0F; cin4 = 1'b0; op4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0; guard = 0;
        while (!done4 && guard < 40) begin
            if (busy4) cyc++;
            @(posedge clk); #1;
            guard++;
        end
        check("d4_done", {31'b0, done4}, 32'd1);
        check("d4_busy_cycles", cyc, 32'd2);
        check("d4_s", {24'b0, s4}, 32'h4B);
        check("d4_cout", {31'b0, cout4}, 32'd0);
        check("d4_ovf", {31'b0, ovf4}, 32'd0);

`ifdef SUMA_ACC_EN
        // accumulator
        run_op("acc0", 8'h10, 8'h05, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0);
        run_op("acc1", 8'hEE, 8'h05, 1'b0, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0);
        run_op("acc_sub", 8'hEE, 8'h1A, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
